// File: rtl/stack_arbiter_pkg.sv
// stack_arb_pkg
// Shared types and helpers for the stack_arbiter slice: the requester opcode
// encoding, the arbiter lock state, and small index helpers used by the
// interface, the round-robin sub-module and the top level.
// Ports: none (package).

package stack_arb_pkg;

   typedef enum logic [1:0] {
      OP_ILLEGAL = 2'b00,
      OP_PUSH    = 2'b01,
      OP_POP     = 2'b10,
      OP_SWAP    = 2'b11
   } op_e;

   typedef enum logic {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Successor of idx in a ring of n requesters.
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if
// Requester-side bundle of the stack arbiter: per-requester valid/op/data/lock
// with one-hot ready, plus the shared one-cycle response.
// Parameters: NUM_REQ (requesters), DATA_WIDTH (stack entry width).
// Modports:
//   master - requester side: drives req_valid/req_op/req_data/req_lock,
//            observes req_ready and rsp_*.
//   slave  - arbiter side: the reverse.

interface stack_arbiter_if
   import stack_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [2*NUM_REQ-1:0]          req_op;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]            req_lock;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          rsp_valid;
   logic [ID_W-1:0]               rsp_id;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          rsp_err;

   modport master (
      output req_valid, req_op, req_data, req_lock,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_data, req_lock,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

endinterface

// File: rtl/stack_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// starting at ptr, upward with wrap, and returns the first hit.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  ID_W     highest-priority index
//   grant     out NUM_REQ  one-hot grant (0 when no request)
//   grant_idx out ID_W     index of the granted requester (0 when none)
//   any_grant out 1        some requester is granted

module rr_arbiter
   import stack_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_grant
);

   // Two passes implement the wrap: first indices at or above ptr,
   // then the ones below it.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_grant && req[i] && (i >= int'(ptr))) begin
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
            any_grant = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_grant && req[i] && (i < int'(ptr))) begin
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter
// Shares one LIFO stack between NUM_REQ requesters. Requests are picked
// round-robin; an accepted request with lock=1 pins the grant to that
// requester until it issues a request with lock=0. Stack controls are driven
// combinationally in the acceptance cycle; the response is registered and
// appears for one cycle after acceptance.
// Build option: define STACK_ARB_SWAP_EN to execute SWAP (op 11); without it
// op 11 is rejected like an illegal op and no SWAP datapath is built.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          stack_arbiter_if.slave requester bundle
//   stk_entry    data to the stack
//   stk_insert   stack insert strobe
//   stk_pop      stack pop strobe (with stk_insert: replace top)
//   stk_top      current stack top (combinational from the stack)
//   stk_full     stack full
//   stk_empty    stack empty
//   locked       arbiter is locked to one requester
//   lock_id      lock owner, 0 when unlocked

module stack_arbiter
   import stack_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   localparam int ID_W      = id_width(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stack_arbiter_if.slave        bus,
   output logic [DATA_WIDTH-1:0] stk_entry,
   output logic                  stk_insert,
   output logic                  stk_pop,
   input  logic [DATA_WIDTH-1:0] stk_top,
   input  logic                  stk_full,
   input  logic                  stk_empty,
   output logic                  locked,
   output logic [ID_W-1:0]       lock_id
);

   arb_state_e            state, state_next;
   logic [ID_W-1:0]       rr_ptr, rr_ptr_next;
   logic [ID_W-1:0]       lock_owner, lock_owner_next;
   logic [NUM_REQ-1:0]    eligible, grant;
   logic [ID_W-1:0]       arb_ptr, grant_idx;
   logic                  accept;
   logic [1:0]            op_sel;
   logic [DATA_WIDTH-1:0] data_sel;
   logic                  lock_sel;
   logic                  do_insert, do_pop, op_err, take_top;

   // While locked only the owner may compete; pointing the search at the
   // owner makes the round-robin picker return it directly.
   always_comb begin
      eligible = bus.req_valid;
      arb_ptr  = rr_ptr;
      if (state == LOCKED) begin
         eligible = bus.req_valid & (NUM_REQ'(1) << lock_owner);
         arb_ptr  = lock_owner;
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (eligible),
      .ptr       (arb_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (accept)
   );

   assign bus.req_ready = grant;

   // One-hot select of the granted requester's fields; all zero without a grant.
   always_comb begin
      op_sel   = '0;
      data_sel = '0;
      lock_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            op_sel   = bus.req_op[2*i +: 2];
            data_sel = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
            lock_sel = bus.req_lock[i];
         end
      end
   end

   // Any rejected operation leaves the stack controls idle.
   always_comb begin
      do_insert = 1'b0;
      do_pop    = 1'b0;
      op_err    = 1'b0;
      take_top  = 1'b0;
      case (op_e'(op_sel))
         OP_PUSH: begin
            if (stk_full) op_err = 1'b1;
            else          do_insert = 1'b1;
         end
         OP_POP: begin
            if (stk_empty) op_err = 1'b1;
            else begin
               do_pop   = 1'b1;
               take_top = 1'b1;
            end
         end
`ifdef STACK_ARB_SWAP_EN
         OP_SWAP: begin
            if (stk_empty) op_err = 1'b1;
            else begin
               do_insert = 1'b1;
               do_pop    = 1'b1;
               take_top  = 1'b1;
            end
         end
`endif
         default: op_err = 1'b1;
      endcase
   end

   assign stk_insert = accept & do_insert;
   assign stk_pop    = accept & do_pop;
   assign stk_entry  = data_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OPEN;
      else        state <= state_next;
   end

   // Errored requests still move the lock state and pointer.
   always_comb begin
      state_next      = state;
      rr_ptr_next     = rr_ptr;
      lock_owner_next = lock_owner;
      case (state)
         OPEN: begin
            if (accept) begin
               rr_ptr_next = ID_W'(next_idx(int'(grant_idx), NUM_REQ));
               if (lock_sel) begin
                  state_next      = LOCKED;
                  lock_owner_next = grant_idx;
               end
            end
         end
         LOCKED: begin
            if (accept && !lock_sel) begin
               state_next      = OPEN;
               rr_ptr_next     = ID_W'(next_idx(int'(lock_owner), NUM_REQ));
               lock_owner_next = '0;
            end
         end
         default: state_next = OPEN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         lock_owner <= '0;
      end else begin
         rr_ptr     <= rr_ptr_next;
         lock_owner <= lock_owner_next;
      end
   end

   // stk_top is sampled at the acceptance edge, i.e. the pre-operation top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= accept;
         bus.rsp_id    <= accept ? grant_idx : '0;
         bus.rsp_data  <= (accept && take_top) ? stk_top : '0;
         bus.rsp_err   <= accept & op_err;
      end
   end

   assign locked  = (state == LOCKED);
   assign lock_id = lock_owner;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter
// Self-checking bench for stack_arbiter with four requesters and a 20-entry
// behavioural stack. Each requester has a command queue it presents until
// accepted; a reference arbiter/stack model predicts the grant and pushes the
// expected response into a scoreboard that is compared one cycle later.
// Expectations for SWAP follow STACK_ARB_SWAP_EN.

module tb_stack_arbiter;
   import stack_arb_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int DW        = 8;
   localparam int ID_W      = 2;
   localparam int LIFO_SIZE = 20;
   localparam int QDEPTH    = 32;

   typedef struct packed {
      logic [1:0]    op;
      logic [DW-1:0] data;
      logic          lock;
   } cmd_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [DW-1:0]   data;
      logic            err;
   } rsp_t;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] stk_entry;
   logic          stk_insert;
   logic          stk_pop;
   logic [DW-1:0] stk_top;
   logic          stk_full;
   logic          stk_empty;
   logic          locked;
   logic [ID_W-1:0] lock_id;

   stack_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

   stack_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .stk_entry  (stk_entry),
      .stk_insert (stk_insert),
      .stk_pop    (stk_pop),
      .stk_top    (stk_top),
      .stk_full   (stk_full),
      .stk_empty  (stk_empty),
      .locked     (locked),
      .lock_id    (lock_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stack driven by the DUT, sharing rst_n.
   logic [DW-1:0] stk_mem [LIFO_SIZE];
   int            stk_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stk_count <= 0;
      end else if (stk_insert && stk_pop) begin
         if (stk_count > 0) stk_mem[stk_count-1] <= stk_entry;
      end else if (stk_insert) begin
         if (stk_count < LIFO_SIZE) begin
            stk_mem[stk_count] <= stk_entry;
            stk_count          <= stk_count + 1;
         end
      end else if (stk_pop) begin
         if (stk_count > 0) stk_count <= stk_count - 1;
      end
   end

   assign stk_top   = (stk_count > 0) ? stk_mem[stk_count-1] : '0;
   assign stk_full  = (stk_count == LIFO_SIZE);
   assign stk_empty = (stk_count == 0);

   // Stimulus queues, scoreboard and reference model state.
   cmd_t          cmds [NUM_REQ][QDEPTH];
   int            head [NUM_REQ];
   int            tail [NUM_REQ];
   rsp_t          sb [$];
   logic [DW-1:0] ref_stk [$];
   int            m_ptr;
   int            m_owner;
   bit            m_locked;
   int            checks;
   int            errors;

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic load_cmd(input int r, input logic [1:0] op,
                           input logic [DW-1:0] data, input logic lock);
      cmds[r][tail[r]] = '{op: op, data: data, lock: lock};
      tail[r]++;
   endtask

   function automatic bit cmds_pending();
      bit p = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (head[i] < tail[i]) p = 1'b1;
      return p;
   endfunction

   task automatic apply_stimulus();
      logic [NUM_REQ-1:0]    v = '0;
      logic [NUM_REQ-1:0]    l = '0;
      logic [2*NUM_REQ-1:0]  o = '0;
      logic [DW*NUM_REQ-1:0] d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head[i] < tail[i]) begin
            v[i]            = 1'b1;
            l[i]            = cmds[i][head[i]].lock;
            o[2*i +: 2]     = cmds[i][head[i]].op;
            d[DW*i +: DW]   = cmds[i][head[i]].data;
         end
      end
      bus.req_valid = v;
      bus.req_lock  = l;
      bus.req_op    = o;
      bus.req_data  = d;
   endtask

   // Reference arbiter + stack: predict this cycle's grant and controls.
   task automatic predict_and_check();
      int            g = -1;
      int            idx;
      cmd_t          c;
      rsp_t          r;
      logic          exp_ins = 1'b0;
      logic          exp_pop = 1'b0;
      logic [NUM_REQ-1:0] exp_ready = '0;
      if (m_locked) begin
         if (head[m_owner] < tail[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && head[idx] < tail[idx]) g = idx;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check_output("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (g >= 0) begin
         c = cmds[g][head[g]];
         head[g]++;
         r = '{id: ID_W'(g), data: '0, err: 1'b0};
         case (c.op)
            2'b01: begin
               if (ref_stk.size() == LIFO_SIZE) r.err = 1'b1;
               else begin
                  ref_stk.push_back(c.data);
                  exp_ins = 1'b1;
               end
            end
            2'b10: begin
               if (ref_stk.size() == 0) r.err = 1'b1;
               else begin
                  r.data  = ref_stk.pop_back();
                  exp_pop = 1'b1;
               end
            end
            2'b11: begin
`ifdef STACK_ARB_SWAP_EN
               if (ref_stk.size() == 0) r.err = 1'b1;
               else begin
                  r.data = ref_stk[ref_stk.size()-1];
                  ref_stk[ref_stk.size()-1] = c.data;
                  exp_ins = 1'b1;
                  exp_pop = 1'b1;
               end
`else
               r.err = 1'b1;
`endif
            end
            default: r.err = 1'b1;
         endcase
         check_output("stk_entry", 32'(stk_entry), 32'(c.data));
         sb.push_back(r);
         if (!m_locked) begin
            m_ptr = (g + 1) % NUM_REQ;
            if (c.lock) begin
               m_locked = 1'b1;
               m_owner  = g;
            end
         end else if (!c.lock) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % NUM_REQ;
            m_owner  = 0;
         end
      end else begin
         check_output("stk_entry_idle", 32'(stk_entry), 32'd0);
      end
      check_output("stk_insert", 32'(stk_insert), 32'(exp_ins));
      check_output("stk_pop", 32'(stk_pop), 32'(exp_pop));
   endtask

   task automatic check_response();
      rsp_t r;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         check_output("rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_output("rsp_id", 32'(bus.rsp_id), 32'(r.id));
         check_output("rsp_data", 32'(bus.rsp_data), 32'(r.data));
         check_output("rsp_err", 32'(bus.rsp_err), 32'(r.err));
      end else begin
         check_output("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
      end
      check_output("locked", 32'(locked), 32'(m_locked));
      check_output("lock_id", 32'(lock_id), 32'(m_owner));
   endtask

   task automatic step_cycle();
      @(negedge clk);
      check_response();
      apply_stimulus();
      #1;
      predict_and_check();
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((cmds_pending() || sb.size() > 0) && n < budget) begin
         step_cycle();
         n++;
      end
      if (cmds_pending() || sb.size() > 0)
         check_output("drain_timeout", 32'd1, 32'd0);
   endtask

   // Reset drops pending responses, the lock and the stack contents.
   task automatic reset_dut();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_lock  = '0;
      bus.req_op    = '0;
      bus.req_data  = '0;
      #1;
      check_output("rst_locked", 32'(locked), 32'd0);
      check_output("rst_lock_id", 32'(lock_id), 32'd0);
      check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_output("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_output("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check_output("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_output("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check_output("rst_stk_ctl", 32'({stk_insert, stk_pop}), 32'd0);
      sb.delete();
      ref_stk.delete();
      for (int i = 0; i < NUM_REQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      m_ptr    = 0;
      m_owner  = 0;
      m_locked = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_lock  = '0;
      bus.req_op    = '0;
      bus.req_data  = '0;
      reset_dut();

      $display("[TB] round-robin pushes from all requesters");
      for (int rep = 0; rep < 3; rep++)
         for (int i = 0; i < NUM_REQ; i++)
            load_cmd(i, OP_PUSH, DW'(8'hA0 + i), 1'b0);
      run_until_idle(200);

      $display("[TB] locked PUSH/POP sequence on requester 2");
      load_cmd(2, OP_PUSH, 8'h55, 1'b1);
      load_cmd(2, OP_POP, 8'h00, 1'b0);
      step_cycle();
      load_cmd(0, OP_PUSH, 8'h30, 1'b0);
      load_cmd(1, OP_PUSH, 8'h31, 1'b0);
      load_cmd(3, OP_PUSH, 8'h33, 1'b0);
      run_until_idle(200);

      $display("[TB] reset while locked with a response pending");
      load_cmd(1, OP_PUSH, 8'h77, 1'b1);
      step_cycle();
      check_output("lock_taken", 32'(m_locked), 32'd1);
      reset_dut();
      for (int i = 0; i < NUM_REQ; i++) load_cmd(i, OP_PUSH, DW'(8'hC0 + i), 1'b0);
      run_until_idle(200);

      $display("[TB] POP on empty stack and illegal op");
      reset_dut();
      load_cmd(0, OP_POP, 8'h00, 1'b0);
      load_cmd(0, OP_ILLEGAL, 8'h99, 1'b0);
      run_until_idle(200);

      $display("[TB] overfill the stack");
      for (int i = 0; i < LIFO_SIZE + 1; i++) load_cmd(1, OP_PUSH, DW'(i + 1), 1'b0);
      run_until_idle(200);
      check_output("stk_full_after_fill", 32'(stk_full), 32'd1);

      $display("[TB] PUSH, SWAP, POP sequence");
      reset_dut();
      load_cmd(3, OP_PUSH, 8'h11, 1'b0);
      load_cmd(3, OP_SWAP, 8'h22, 1'b0);
      load_cmd(3, OP_POP, 8'h00, 1'b0);
      run_until_idle(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
